// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-port main-memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned ADDR_W_DEF = 28;
    localparam int unsigned DATA_W_DEF = 128;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Two-way round-robin selector: picks the pending port, or on a tie the one not served last.
module mem_arbiter_pick
    import mem_arbiter_pkg::*;
(
    input  logic req_i,
    input  logic req_d,
    input  logic last,
    output logic grant_valid,
    output logic grant_port
);

    always_comb begin
        grant_valid = req_i | req_d;
        grant_port  = PORT_I;
        if (req_i && req_d) begin
            grant_port = ~last;
        end else if (req_d) begin
            grant_port = PORT_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Serialises I-cache refills and D-cache refills/write-backs onto one block-wide memory port.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              I_READ,
    input  logic [ADDR_W-1:0] I_ADDRESS,
    output logic [DATA_W-1:0] I_READDATA,
    output logic              I_BUSYWAIT,
    input  logic              D_READ,
    input  logic              D_WRITE,
    input  logic [ADDR_W-1:0] D_ADDRESS,
    input  logic [DATA_W-1:0] D_WRITEDATA,
    output logic [DATA_W-1:0] D_READDATA,
    output logic              D_BUSYWAIT,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [ADDR_W-1:0] MEM_ADDRESS,
    output logic [DATA_W-1:0] MEM_WRITEDATA,
    input  logic [DATA_W-1:0] MEM_READDATA,
    input  logic              MEM_BUSYWAIT
);

    state_t state_q, state_d;
    logic   last_q;
    logic   done_i_q, done_d_q;
    logic   req_i, req_d;
    logic   grant_valid, grant_port;
    logic   start_c, finish_c;

    // A port is masked for the cycle after its completion so it is never regranted on a stale request.
    assign req_i      = I_READ & ~done_i_q;
    assign req_d      = (D_READ | D_WRITE) & ~done_d_q;
    assign I_BUSYWAIT = req_i;
    assign D_BUSYWAIT = req_d;

    mem_arbiter_pick u_pick (
        .req_i       (req_i),
        .req_d       (req_d),
        .last        (last_q),
        .grant_valid (grant_valid),
        .grant_port  (grant_port)
    );

    always_comb begin
        state_d  = state_q;
        start_c  = 1'b0;
        finish_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    start_c = 1'b1;
                    state_d = (grant_port == PORT_D) ? GRANT_D : GRANT_I;
                end
            end
            GRANT_I, GRANT_D: begin
                if (!MEM_BUSYWAIT) begin
                    finish_c = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Command registers hold the granted request; requester inputs are ignored until completion.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q       <= IDLE;
            last_q        <= PORT_I;
            done_i_q      <= 1'b0;
            done_d_q      <= 1'b0;
            MEM_READ      <= 1'b0;
            MEM_WRITE     <= 1'b0;
            MEM_ADDRESS   <= '0;
            MEM_WRITEDATA <= '0;
            I_READDATA    <= '0;
            D_READDATA    <= '0;
        end else begin
            state_q  <= state_d;
            done_i_q <= finish_c && (state_q == GRANT_I);
            done_d_q <= finish_c && (state_q == GRANT_D);
            if (start_c) begin
                MEM_ADDRESS <= (grant_port == PORT_D) ? D_ADDRESS : I_ADDRESS;
                if (grant_port == PORT_D) begin
                    MEM_WRITEDATA <= D_WRITEDATA;
                end
                // Simultaneous D read and write is resolved as a write.
                MEM_WRITE <= (grant_port == PORT_D) && D_WRITE;
                MEM_READ  <= (grant_port == PORT_I) || !D_WRITE;
            end else if (finish_c) begin
                MEM_READ  <= 1'b0;
                MEM_WRITE <= 1'b0;
                last_q    <= (state_q == GRANT_D) ? PORT_D : PORT_I;
                if (MEM_READ && (state_q == GRANT_I)) begin
                    I_READDATA <= MEM_READDATA;
                end
                if (MEM_READ && (state_q == GRANT_D)) begin
                    D_READDATA <= MEM_READDATA;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: single-port vector table plus arbitration and reset sequences.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int unsigned AW = 28;
    localparam int unsigned DW = 128;
    localparam int unsigned NV = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read, d_read, d_write;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic [DW-1:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
    logic          i_busy, d_busy, mem_read, mem_write, mem_busy;

    int            lat = 1;
    int            cnt = 0;
    int            total = 0;
    int            bad = 0;
    int            cyc;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic [AW-1:0] cpl_q[$];
    logic [DW-1:0] exp_i_rd, exp_d_rd, pat;
    logic [AW-1:0] exp_order[4];

    typedef struct {
        logic          i_read;
        logic          d_read;
        logic          d_write;
        logic [AW-1:0] i_addr;
        logic [AW-1:0] d_addr;
        logic [DW-1:0] wdata;
        int            lat;
        logic [DW-1:0] rdata;
        logic          exp_rd;
        logic          exp_wr;
        logic [AW-1:0] exp_addr;
    } vec_t;

    vec_t vec[NV];

    always #5 clk = ~clk;

    mem_arbiter dut (
        .CLK           (clk),
        .RESET         (rst),
        .I_READ        (i_read),
        .I_ADDRESS     (i_addr),
        .I_READDATA    (i_rdata),
        .I_BUSYWAIT    (i_busy),
        .D_READ        (d_read),
        .D_WRITE       (d_write),
        .D_ADDRESS     (d_addr),
        .D_WRITEDATA   (d_wdata),
        .D_READDATA    (d_rdata),
        .D_BUSYWAIT    (d_busy),
        .MEM_READ      (mem_read),
        .MEM_WRITE     (mem_write),
        .MEM_ADDRESS   (mem_addr),
        .MEM_WRITEDATA (mem_wdata),
        .MEM_READDATA  (mem_rdata),
        .MEM_BUSYWAIT  (mem_busy)
    );

    // Memory model: busy while a command is up until it has been asserted for lat cycles.
    assign mem_busy = (mem_read | mem_write) && (cnt < lat - 1);

    always @(posedge clk) begin
        if (rst || !(mem_read | mem_write)) cnt <= 0;
        else cnt <= cnt + 1;
        if (!rst && (mem_read | mem_write) && !mem_busy) begin
            cpl_q.push_back(mem_addr);
            if (mem_write) begin
                wr_addr <= mem_addr;
                wr_data <= mem_wdata;
            end
        end
    end

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic pulse_reset();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
        exp_i_rd = '0; exp_d_rd = '0;

        vec[0] = '{1'b1, 1'b0, 1'b0, 28'h0000010, 28'h0000000, '0, 5,
                   {16{8'hA5}}, 1'b1, 1'b0, 28'h0000010};
        vec[1] = '{1'b0, 1'b1, 1'b0, 28'h0000000, 28'h0ABCDEF, '0, 1,
                   128'h0123456789ABCDEF_FEDCBA9876543210, 1'b1, 1'b0, 28'h0ABCDEF};
        vec[2] = '{1'b0, 1'b0, 1'b1, 28'h0000000, 28'h0000020,
                   128'hDEADBEEF_00000001_CAFEF00D_12345678, 3, '0, 1'b0, 1'b1, 28'h0000020};
        vec[3] = '{1'b0, 1'b1, 1'b1, 28'h0000000, 28'hFFFFFFF, '1, 2,
                   {16{8'h11}}, 1'b0, 1'b1, 28'hFFFFFFF};
        vec[4] = '{1'b1, 1'b0, 1'b0, 28'h0000000, 28'h0000000, '0, 1,
                   {16{8'h5A}}, 1'b1, 1'b0, 28'h0000000};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        smp();
        chk("rst_mem_read", DW'(mem_read), DW'(1'b0));
        chk("rst_mem_write", DW'(mem_write), DW'(1'b0));
        chk("rst_mem_addr", DW'(mem_addr), '0);
        chk("rst_mem_wdata", mem_wdata, '0);
        chk("rst_i_busy", DW'(i_busy), DW'(1'b0));
        chk("rst_d_busy", DW'(d_busy), DW'(1'b0));
        chk("rst_i_rdata", i_rdata, '0);
        chk("rst_d_rdata", d_rdata, '0);

        // Single-port transactions from the table.
        for (int k = 0; k < int'(NV); k++) begin
            tick();
            i_read = vec[k].i_read; d_read = vec[k].d_read; d_write = vec[k].d_write;
            i_addr = vec[k].i_addr; d_addr = vec[k].d_addr; d_wdata = vec[k].wdata;
            lat = vec[k].lat; mem_rdata = vec[k].rdata;
            smp();
            chk($sformatf("v%0d_busy_c0", k), DW'(vec[k].i_read ? i_busy : d_busy), DW'(1'b1));
            tick(); smp();
            chk($sformatf("v%0d_mem_read", k), DW'(mem_read), DW'(vec[k].exp_rd));
            chk($sformatf("v%0d_mem_write", k), DW'(mem_write), DW'(vec[k].exp_wr));
            chk($sformatf("v%0d_mem_addr", k), DW'(mem_addr), DW'(vec[k].exp_addr));
            if (vec[k].exp_wr) chk($sformatf("v%0d_mem_wdata", k), mem_wdata, vec[k].wdata);
            cyc = 1;
            while ((vec[k].i_read ? i_busy : d_busy) && cyc < 100) begin
                tick(); smp(); cyc++;
                if (vec[k].i_read ? i_busy : d_busy)
                    chk($sformatf("v%0d_cmd_held_c%0d", k, cyc),
                        DW'({mem_read, mem_write}), DW'({vec[k].exp_rd, vec[k].exp_wr}));
            end
            chk($sformatf("v%0d_done_cycle", k), DW'(cyc), DW'(vec[k].lat + 1));
            if (vec[k].exp_rd && vec[k].i_read) exp_i_rd = vec[k].rdata;
            if (vec[k].exp_rd && !vec[k].i_read) exp_d_rd = vec[k].rdata;
            chk($sformatf("v%0d_i_rdata", k), i_rdata, exp_i_rd);
            chk($sformatf("v%0d_d_rdata", k), d_rdata, exp_d_rd);
            if (vec[k].exp_wr) begin
                chk($sformatf("v%0d_wr_addr", k), DW'(wr_addr), DW'(vec[k].exp_addr));
                chk($sformatf("v%0d_wr_data", k), wr_data, vec[k].wdata);
            end
        end
        tick();
        i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;

        // Tie after reset: D wins, I follows after one idle cycle.
        pulse_reset();
        pat = {16{8'h3C}};
        i_read = 1'b1; i_addr = 28'h0000040;
        d_write = 1'b1; d_addr = 28'h0000050; d_wdata = {16{8'h77}};
        lat = 2; mem_rdata = pat;
        smp();
        tick(); smp();
        chk("tie_c1_write", DW'({mem_read, mem_write}), DW'(2'b01));
        chk("tie_c1_addr", DW'(mem_addr), DW'(28'h0000050));
        tick(); smp();
        tick(); smp();
        chk("tie_c3_d_busy", DW'(d_busy), DW'(1'b0));
        chk("tie_c3_i_busy", DW'(i_busy), DW'(1'b1));
        chk("tie_c3_idle", DW'({mem_read, mem_write}), DW'(2'b00));
        tick();
        d_write = 1'b0;
        smp();
        chk("tie_c4_read", DW'({mem_read, mem_write}), DW'(2'b10));
        chk("tie_c4_addr", DW'(mem_addr), DW'(28'h0000040));
        tick(); smp();
        tick(); smp();
        chk("tie_c6_i_busy", DW'(i_busy), DW'(1'b0));
        chk("tie_i_rdata", i_rdata, pat);
        chk("tie_wr_addr", DW'(wr_addr), DW'(28'h0000050));
        tick();
        i_read = 1'b0;

        // Both ports held: grants alternate D, I, D, I.
        pulse_reset();
        cpl_q.delete();
        i_read = 1'b1; i_addr = 28'h0000100;
        d_read = 1'b1; d_addr = 28'h0000200;
        lat = 1;
        exp_order[0] = 28'h0000200; exp_order[1] = 28'h0000100;
        exp_order[2] = 28'h0000200; exp_order[3] = 28'h0000100;
        cyc = 0;
        while (cpl_q.size() < 4 && cyc < 50) begin
            tick(); cyc++;
        end
        i_read = 1'b0; d_read = 1'b0;
        smp();
        chk("rr_count", DW'(cpl_q.size() >= 4), DW'(1'b1));
        for (int j = 0; j < 4; j++)
            if (cpl_q.size() > j) chk($sformatf("rr_order_%0d", j), DW'(cpl_q[j]), DW'(exp_order[j]));

        // D address changes mid-grant; the latched address must be used.
        pulse_reset();
        cpl_q.delete();
        pat = {4{32'hCAFE0001}};
        d_read = 1'b1; d_addr = 28'h0000001; lat = 4; mem_rdata = pat;
        smp();
        tick(); smp();
        chk("mid_c1_addr", DW'(mem_addr), DW'(28'h0000001));
        tick();
        d_addr = 28'h0000002;
        smp();
        chk("mid_c2_addr", DW'(mem_addr), DW'(28'h0000001));
        tick(); smp();
        chk("mid_c3_addr", DW'(mem_addr), DW'(28'h0000001));
        tick(); smp();
        chk("mid_c4_addr", DW'(mem_addr), DW'(28'h0000001));
        tick(); smp();
        chk("mid_c5_d_busy", DW'(d_busy), DW'(1'b0));
        chk("mid_d_rdata", d_rdata, pat);
        chk("mid_cpl_count", DW'(cpl_q.size()), DW'(1));
        if (cpl_q.size() > 0) chk("mid_cpl_addr", DW'(cpl_q[0]), DW'(28'h0000001));
        tick();
        d_read = 1'b0;

        // Reset during a D write: abandoned, then regranted.
        tick();
        d_write = 1'b1; d_addr = 28'h0000033; d_wdata = {8{16'h7E57}}; lat = 10;
        smp();
        tick(); smp();
        chk("rstg_c1_write", DW'(mem_write), DW'(1'b1));
        tick();
        rst = 1'b1;
        smp();
        tick();
        rst = 1'b0;
        lat = 2;
        smp();
        chk("rstg_c3_cmd", DW'({mem_read, mem_write}), DW'(2'b00));
        chk("rstg_c3_d_rdata", d_rdata, '0);
        chk("rstg_c3_d_busy", DW'(d_busy), DW'(1'b1));
        tick(); smp();
        chk("rstg_c4_write", DW'(mem_write), DW'(1'b1));
        chk("rstg_c4_addr", DW'(mem_addr), DW'(28'h0000033));
        tick(); smp();
        tick(); smp();
        chk("rstg_c6_d_busy", DW'(d_busy), DW'(1'b0));
        chk("rstg_wr_addr", DW'(wr_addr), DW'(28'h0000033));
        chk("rstg_wr_data", wr_data, {8{16'h7E57}});
        tick();
        d_write = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
